// File: rtl/bf_cfg_pkg.sv
// Shared definitions for the bloom-filter config write path: op encodings,
// write-controller FSM states and default geometry of the config RAM group.
package bf_cfg_pkg;

  localparam logic BF_CFG_OP_SINGLE = 1'b0;
  localparam logic BF_CFG_OP_FILL   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } bf_cfg_state_e;

  localparam int unsigned BF_CFG_SEL_WIDTH  = 6;
  localparam int unsigned BF_CFG_ADDR_WIDTH = 7;
  localparam int unsigned BF_CFG_DATA_WIDTH = 64;
  localparam int unsigned BF_CFG_LEN_WIDTH  = 8;
  localparam int unsigned BF_CFG_SRAM_NUM   = 48;
  localparam int unsigned BF_CFG_CFG_DEPTH  = 128;

endpackage

// File: rtl/bf_cfg_cmd_fifo.sv
// Command FIFO for the config write controller. DEPTH must be a power of two
// (>= 2). Pointers carry one extra wrap bit so full/empty come straight from
// registered state. Push while full and pop while empty are ignored.
module bf_cfg_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bf_cfg_write_ctrl.sv
// Bloom-filter config RAM write controller. Buffers single-word and fill
// commands, validates them, and issues one registered RAM write per cycle,
// pausing while cfg_hold is high.
// Optional macro BF_CFG_WR_STATS_EN adds wr_count / err_count outputs.
module bf_cfg_write_ctrl
  import bf_cfg_pkg::*;
#(
  parameter int unsigned SEL_WIDTH  = BF_CFG_SEL_WIDTH,
  parameter int unsigned ADDR_WIDTH = BF_CFG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BF_CFG_DATA_WIDTH,
  parameter int unsigned CFG_DEPTH  = BF_CFG_CFG_DEPTH,
  parameter int unsigned SRAM_NUM   = BF_CFG_SRAM_NUM,
  parameter int unsigned LEN_WIDTH  = BF_CFG_LEN_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cfg_hold,
  output logic [SEL_WIDTH-1:0]  bf_cfg_sram_sel,
  output logic [ADDR_WIDTH-1:0] bf_cfg_addr_write,
  output logic                  bf_cfg_wr_en,
  output logic [DATA_WIDTH-1:0] bf_cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef BF_CFG_WR_STATS_EN
  ,
  output logic [31:0]           wr_count,
  output logic [15:0]           err_count
`endif
);

  localparam int unsigned CMD_W = 1 + SEL_WIDTH + ADDR_WIDTH + LEN_WIDTH + DATA_WIDTH;
  localparam logic [SEL_WIDTH:0]    SRAM_NUM_W = (SEL_WIDTH+1)'(SRAM_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CFG_DEPTH - 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CMD_W-1:0]      fifo_rdata;
  logic                  h_op;
  logic [SEL_WIDTH-1:0]  h_sel;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [LEN_WIDTH-1:0]  h_len;
  logic [DATA_WIDTH-1:0] h_data;

  bf_cfg_state_e         state_q, state_d;
  logic                  op_q, op_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  out_sel_d;
  logic [ADDR_WIDTH-1:0] out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic                  wr_en_d;
  logic                  done_d;
  logic                  err_d;

  // Gated by rst_n so the port reads 0 in reset yet accepts on the first
  // edge after release.
  assign cmd_ready = rst_n && !fifo_full;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

  bf_cfg_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_op, cmd_sel, cmd_addr, cmd_len, cmd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {h_op, h_sel, h_addr, h_len, h_data} = fifo_rdata;

  // Next-state, working-register and output-register logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    out_sel_d  = bf_cfg_sram_sel;
    out_addr_d = bf_cfg_addr_write;
    out_data_d = bf_cfg_data;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          // rem holds the raw length until LOAD resolves it by op.
          fifo_pop = 1'b1;
          op_d     = h_op;
          sel_d    = h_sel;
          addr_d   = h_addr;
          rem_d    = h_len;
          data_d   = h_data;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (({1'b0, sel_q} >= SRAM_NUM_W) ||
            (op_q == BF_CFG_OP_FILL && rem_q == '0)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (op_q == BF_CFG_OP_SINGLE) rem_d = LEN_WIDTH'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!cfg_hold) begin
          wr_en_d    = 1'b1;
          out_sel_d  = sel_q;
          out_addr_d = addr_q;
          out_data_d = data_q;
          if (rem_q == LEN_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and registered RAM-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      op_q              <= 1'b0;
      sel_q             <= '0;
      addr_q            <= '0;
      rem_q             <= '0;
      data_q            <= '0;
      bf_cfg_sram_sel   <= '0;
      bf_cfg_addr_write <= '0;
      bf_cfg_data       <= '0;
      bf_cfg_wr_en      <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_d;
      sel_q             <= sel_d;
      addr_q            <= addr_d;
      rem_q             <= rem_d;
      data_q            <= data_d;
      bf_cfg_sram_sel   <= out_sel_d;
      bf_cfg_addr_write <= out_addr_d;
      bf_cfg_data       <= out_data_d;
      bf_cfg_wr_en      <= wr_en_d;
      done              <= done_d;
      err               <= err_d;
    end
  end

`ifdef BF_CFG_WR_STATS_EN
  // Saturating write and error counters, updated with the registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (wr_en_d && wr_count != '1)  wr_count  <= wr_count + 32'd1;
      if (err_d && err_count != '1)   err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_cfg_write_ctrl.sv
// Directed self-checking bench for bf_cfg_write_ctrl (default build).
module tb_bf_cfg_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [5:0]  cmd_sel = '0;
  logic [6:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        cfg_hold = 1'b0;
  logic [5:0]  bf_cfg_sram_sel;
  logic [6:0]  bf_cfg_addr_write;
  logic        bf_cfg_wr_en;
  logic [63:0] bf_cfg_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int push_cyc = 0;

  typedef struct {
    int          cyc;
    logic [5:0]  sel;
    logic [6:0]  addr;
    logic [63:0] data;
    logic        done;
    logic        err;
  } wr_t;
  typedef struct {
    int   cyc;
    logic err;
    logic wr;
  } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  bf_cfg_write_ctrl #(
    .SEL_WIDTH  (6),
    .ADDR_WIDTH (7),
    .DATA_WIDTH (64),
    .CFG_DEPTH  (128),
    .SRAM_NUM   (48),
    .LEN_WIDTH  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_sel           (cmd_sel),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .cmd_data          (cmd_data),
    .cfg_hold          (cfg_hold),
    .bf_cfg_sram_sel   (bf_cfg_sram_sel),
    .bf_cfg_addr_write (bf_cfg_addr_write),
    .bf_cfg_wr_en      (bf_cfg_wr_en),
    .bf_cfg_data       (bf_cfg_data),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bf_cfg_wr_en)
      wq.push_back('{cyc, bf_cfg_sram_sel, bf_cfg_addr_write, bf_cfg_data, done, err});
    if (rst_n && done)
      dq.push_back('{cyc, err, bf_cfg_wr_en});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one command from a negedge; returns at the negedge after acceptance.
  task automatic push_cmd(input logic op, input logic [5:0] sel, input logic [6:0] addr,
                          input logic [7:0] len, input logic [63:0] data);
    int t = 0;
    cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_val("push_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 push_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk);
    #1;
    while (busy && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 500) check_val("idle_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int t;
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check_val("rst_wr_en", 64'(bf_cfg_wr_en), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ready", 64'(cmd_ready), 64'd0);
    check_val("rst_addr", 64'(bf_cfg_addr_write), 64'd0);
    check_val("rst_data", bf_cfg_data, 64'd0);
    rst_n = 1'b1;
    #1 check_val("ready_after_rst", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // ---------------- single write ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b0, 6'd5, 7'h10, 8'd0, 64'hDEADBEEF_00000001);
    wait_idle();
    check_val("single_count", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) begin
      check_val("single_latency", 64'(wq[0].cyc - push_cyc), 64'd3);
      check_val("single_sel", 64'(wq[0].sel), 64'd5);
      check_val("single_addr", 64'(wq[0].addr), 64'h10);
      check_val("single_data", wq[0].data, 64'hDEADBEEF_00000001);
      check_val("single_done", 64'(wq[0].done), 64'd1);
      check_val("single_err", 64'(wq[0].err), 64'd0);
    end
    check_val("single_done_cnt", 64'(dq.size()), 64'd1);

    // ---------------- fill clipped at top address ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b1, 6'd2, 7'h7C, 8'd8, 64'h1234_5678_9ABC_DEF0);
    wait_idle();
    check_val("clip_count", 64'(wq.size()), 64'd4);
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      check_val($sformatf("clip_addr%0d", i), 64'(wq[i].addr), 64'(7'h7C + i));
      check_val($sformatf("clip_done%0d", i), 64'(wq[i].done), (i == 3) ? 64'd1 : 64'd0);
      check_val($sformatf("clip_err%0d", i), 64'(wq[i].err), (i == 3) ? 64'd1 : 64'd0);
    end
    if (wq.size() >= 1) check_val("clip_sel", 64'(wq[0].sel), 64'd2);
    check_val("clip_done_cnt", 64'(dq.size()), 64'd1);

    // ---------------- fill with hold ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b1, 6'd3, 7'h20, 8'd6, 64'hA5A5_0000_0000_5A5A);
    t = 0;
    while (wq.size() < 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) check_val("hold_wait_timeout", 64'd1, 64'd0);
    cfg_hold = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cfg_hold = 1'b0;
    wait_idle();
    check_val("hold_count", 64'(wq.size()), 64'd6);
    for (int i = 0; i < wq.size() && i < 6; i++)
      check_val($sformatf("hold_addr%0d", i), 64'(wq[i].addr), 64'(7'h20 + i));
    if (wq.size() >= 6) begin
      check_val("hold_gap_1_2", 64'(wq[1].cyc - wq[0].cyc), 64'd1);
      check_val("hold_gap_2_3", 64'(wq[2].cyc - wq[1].cyc), 64'd4);
      check_val("hold_gap_3_4", 64'(wq[3].cyc - wq[2].cyc), 64'd1);
      check_val("hold_last_err", 64'(wq[5].err), 64'd0);
      check_val("hold_data", wq[4].data, 64'hA5A5_0000_0000_5A5A);
    end

    // ---------------- FIFO full / ordering ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b1, 6'd1, 7'h00, 8'd20, 64'hF00D);
    for (int i = 0; i < 4; i++)
      push_cmd(1'b0, 6'(10 + i), 7'(7'h40 + i), 8'd0, 64'(i + 1));
    #1 check_val("fifo_full_ready", 64'(cmd_ready), 64'd0);
    push_cmd(1'b0, 6'd14, 7'h44, 8'd0, 64'd5);
    wait_idle();
    check_val("order_count", 64'(wq.size()), 64'd25);
    if (wq.size() >= 25) begin
      for (int i = 0; i < 5; i++) begin
        check_val($sformatf("order_sel%0d", i), 64'(wq[20 + i].sel), 64'(10 + i));
        check_val($sformatf("order_addr%0d", i), 64'(wq[20 + i].addr), 64'(7'h40 + i));
        check_val($sformatf("order_data%0d", i), wq[20 + i].data, 64'(i + 1));
      end
      check_val("order_fill_last", 64'(wq[19].addr), 64'd19);
      check_val("b2b_gap", 64'(wq[21].cyc - wq[20].cyc), 64'd3);
    end

    // ---------------- bad commands ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b0, 6'd48, 7'h01, 8'd0, 64'h11);
    push_cmd(1'b1, 6'd4, 7'h02, 8'd0, 64'h22);
    push_cmd(1'b0, 6'd7, 7'h55, 8'd0, 64'h0123_4567_89AB_CDEF);
    wait_idle();
    check_val("bad_wr_count", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) begin
      check_val("bad_next_sel", 64'(wq[0].sel), 64'd7);
      check_val("bad_next_addr", 64'(wq[0].addr), 64'h55);
      check_val("bad_next_data", wq[0].data, 64'h0123_4567_89AB_CDEF);
    end
    check_val("bad_done_cnt", 64'(dq.size()), 64'd3);
    if (dq.size() >= 3) begin
      check_val("bad_sel_err", 64'(dq[0].err), 64'd1);
      check_val("bad_sel_wr", 64'(dq[0].wr), 64'd0);
      check_val("bad_len_err", 64'(dq[1].err), 64'd1);
      check_val("bad_len_wr", 64'(dq[1].wr), 64'd0);
      check_val("good_err", 64'(dq[2].err), 64'd0);
    end

    // ---------------- reset mid-fill ----------------
    wq.delete(); dq.delete();
    push_cmd(1'b1, 6'd9, 7'h00, 8'd10, 64'hCAFE);
    t = 0;
    while (wq.size() < 3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) check_val("rst_wait_timeout", 64'd1, 64'd0);
    check_val("pre_rst_wr_en", 64'(bf_cfg_wr_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rst_wr_en", 64'(bf_cfg_wr_en), 64'd0);
    check_val("async_rst_busy", 64'(busy), 64'd0);
    check_val("async_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_val("post_rst_writes", 64'(wq.size()), 64'd3);
    check_val("post_rst_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
